// File: rtl/tl_ram_responder.sv
// Single-beat TileLink-UL responder backed by a 64-bit wide synchronous RAM.
// One request in flight: capture in IDLE, access the RAM in ACCESS, hold D in RESP.
module tl_ram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [5:0]  SINK_ID    = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [5:0]  d_sink,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;

  state_t state, state_next;

  logic [2:0]  op_r;
  logic [2:0]  size_r;
  logic [3:0]  source_r;
  logic [63:0] addr_r;
  logic [7:0]  mask_r;
  logic [63:0] data_r;
  logic        corrupt_r;

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [2:0]            size_span;
  logic                  is_get, is_put, op_bad, misaligned, out_of_range, deny;
  logic                  capture, access, d_fire;

  // a_param carries no meaning for this responder
  logic unused_param;
  assign unused_param = ^a_param;

  assign capture = (state == IDLE) && a_valid;
  assign access  = (state == ACCESS);
  assign d_fire  = d_valid && d_ready;

  assign word_idx     = addr_r[DEPTH_LOG2+2:3];
  assign size_span    = 3'((4'd1 << size_r[1:0]) - 4'd1);
  assign is_get       = (op_r == OP_GET);
  assign is_put       = (op_r == OP_PUT_FULL) || (op_r == OP_PUT_PARTIAL);
  assign op_bad       = !(is_get || is_put);
  assign misaligned   = |(addr_r[2:0] & size_span);
  assign out_of_range = |addr_r[63:DEPTH_LOG2+3];
  assign deny         = op_bad || size_r[2] || misaligned || out_of_range ||
                        (is_put && corrupt_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    case (state)
      IDLE: begin
        a_ready = 1'b1;
        if (a_valid) state_next = ACCESS;
      end
      ACCESS: state_next = RESP;
      RESP:   if (d_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      size_r    <= '0;
      source_r  <= '0;
      addr_r    <= '0;
      mask_r    <= '0;
      data_r    <= '0;
      corrupt_r <= 1'b0;
    end else if (capture) begin
      op_r      <= a_opcode;
      size_r    <= a_size;
      source_r  <= a_source;
      addr_r    <= a_address;
      mask_r    <= a_mask;
      data_r    <= a_data;
      corrupt_r <= a_corrupt;
    end
  end

  // RAM has no reset; an async reset during ACCESS leaves state != ACCESS at the edge
  always_ff @(posedge clk) begin
    if (access && is_put && !deny) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (mask_r[k]) mem[word_idx][8*k +: 8] <= data_r[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid   <= 1'b0;
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else if (access) begin
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? 3'd1 : 3'd0;
      d_size    <= size_r;
      d_source  <= source_r;
      d_denied  <= deny;
      d_data    <= (is_get && !deny) ? mem[word_idx] : '0;
      d_corrupt <= is_get && deny;
    end else if (d_fire) begin
      d_valid   <= 1'b0;
    end
  end

  assign d_param = '0;
  assign d_sink  = SINK_ID;

endmodule

// File: doc/tl_ram_responder.md
# tl_ram_responder

- Single-beat TileLink-UL responder: a synchronous SRAM on one crossbar slave port.
- Accepts Get / PutFullData / PutPartialData on the A channel and returns AccessAckData / AccessAck on the D channel.
- Holds one request at a time and denies illegal requests.
- The address it receives is already chip-relative: the crossbar's PMA decode has removed the chip-select bits.

## Interface
- DEPTH_LOG2, default 10: RAM holds 2**DEPTH_LOG2 words of 64 bits (default 8 KiB).
- SINK_ID, default 6'd0: constant driven on d_sink.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; any other value is unsupported.
- a_param  in  3  ignored.
- a_size  in  3  log2 of the byte count; 0..3 legal.
- a_source  in  4  request ID, echoed on D.
- a_address  in  64  chip-relative byte address.
- a_mask  in  8  byte-lane write enables.
- a_data  in  64  write data.
- a_corrupt  in  1  write data poisoned.
- a_valid  in  1  A beat valid.
- a_ready  out  1  responder can accept an A beat.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  4  echo of a_source.
- d_sink  out  6  SINK_ID.
- d_denied  out  1  request rejected.
- d_data  out  64  read data.
- d_corrupt  out  1  read data invalid.
- d_valid  out  1  D beat valid.
- d_ready  in  1  initiator accepts the D beat.

## Operation
- FSM with three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - a_ready=1.
  - On a_valid & a_ready, register opcode, size, source, address, mask, data and corrupt, then go to ACCESS.
- ACCESS:
  - a_ready=0.
  - Decode the registered request into `deny`, which is set if any of these hold:
    - opcode is not in {0,1,4};
    - size > 3;
    - address[2:0] & ((1<<size)-1) != 0 (misaligned);
    - address[63:DEPTH_LOG2+3] != 0 (out of range);
    - a Put with corrupt=1.
  - Legal Put: write word address[DEPTH_LOG2+2:3]; byte lane k is written iff mask[k]=1. Mask is applied as given, with no consistency check against size or address.
  - Legal Get: RAM read of the same word.
  - Denied request: no RAM write.
  - Next state is RESP.
- RESP:
  - Hold d_valid=1 with all D fields stable until d_valid & d_ready, then go to IDLE.
- D field values in RESP:
  - d_opcode = 1 if the registered opcode was Get, else 0. An unsupported opcode returns 0 with d_denied=1.
  - d_data: the full 64-bit word, all lanes, for a legal Get; 0 otherwise.
  - d_corrupt = 1 only for a denied Get.
  - d_denied = deny.
- RAM is not reset; its contents are undefined until written.
- The responder never issues D without a prior A, and never has more than one request outstanding.

## Timing
- Reset (asynchronous assert):
  - state=IDLE; d_valid=0.
  - All registered D fields are 0, except d_sink=SINK_ID.
  - a_ready=1 once state is IDLE.
- Latency:
  - A handshake at edge N → ACCESS during cycle N..N+1.
  - d_valid rises after edge N+1, i.e. visible in the cycle following ACCESS.
  - RAM write commits at edge N+1.
- After D handshake at edge M: state=IDLE and a_ready=1 in cycle M..M+1. A new A handshake is possible at edge M+1.
- Minimum 3 cycles per transaction.
- a_ready is a function of state only (registered state, no combinational path from a_valid). d_valid is registered.
- Back-pressure: d_ready held low keeps RESP indefinitely with D fields frozen; a_ready stays 0 throughout.
- a_valid high while not in IDLE: ignored, no capture.
- Reset asserted in ACCESS before the edge: no write occurs, d_valid drops immediately, and the request is lost.
- Reset asserted in RESP: d_valid drops immediately and the response is lost.

## Test plan
- PutFullData size=3, address 0x40, data 0x1122334455667788, mask 0xFF, source 5 → AccessAck (d_opcode=0), d_source=5, d_size=3, d_denied=0, d_valid 2 cycles after the A handshake. A following Get to 0x40 → d_opcode=1, d_data=0x1122334455667788, d_corrupt=0.
- PutPartialData size=0, address 0x43, mask 0x08, data 0x00000000AA000000 after the above → Get 0x40 returns 0x11223344AA667788.
- Get size=2 at address 0x42 (misaligned) → d_denied=1, d_corrupt=1, d_data=0, d_opcode=1. Put size=3 at 0x2000 with DEPTH_LOG2=10 (out of range) → d_denied=1, d_opcode=0; a later Get 0x0 is unaffected.
- Opcode 2 (Arithmetic) → d_opcode=0, d_denied=1, no RAM change. PutFullData with a_corrupt=1 → d_denied=1, word unchanged.
- Hold d_ready=0 for 10 cycles in RESP while a_valid pulses → D fields stable, a_ready=0, no second capture. Release d_ready → handshake, then a_ready=1 the next cycle.
- Assert rst_n low during ACCESS of a Put to 0x80 → d_valid=0 and a_ready=1 immediately. After release, Get 0x80 shows no write from the aborted Put.
